// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
//
// Writeback stage and register scoreboard sitting in front of the RV32I
// register file write port. Completed results from the execution units are
// buffered in a small FIFO and drained one per cycle into the register file.
// A busy bit per architectural register stalls issue on RAW/WAW hazards
// against writes that are still in flight.
//
// Configuration macro:
//   WB_SCOREBOARD_BYPASS_EN - when defined, a source register whose result is
//                             on the write port this cycle is not a hazard;
//                             fwd_rs*_o tells decode to take wb_data_o.
//
// Ports:
//   clk_i, rst_i          clock / synchronous active-low reset
//   iss_valid_i           decode presents an instruction
//   iss_ready_o           no hazard, issue accepted this cycle
//   iss_rs1_i/iss_rs2_i   source registers
//   iss_rd_i/iss_rd_we_i  destination register and its write enable
//   cmp_valid_i           execution unit presents a result
//   cmp_ready_o           completion FIFO has room
//   cmp_rd_i/cmp_data_i   result destination and value
//   wb_we_o/wb_addr_o/
//   wb_data_o             register file write port (FIFO head)
//   fwd_rs1_o/fwd_rs2_o   source must be taken from wb_data_o this cycle
//   err_o                 sticky: result arrived for a non-busy register
// ---------------------------------------------------------------------------
module wb_scoreboard #(
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            iss_valid_i,
   output logic            iss_ready_o,
   input  logic [4:0]      iss_rs1_i,
   input  logic [4:0]      iss_rs2_i,
   input  logic [4:0]      iss_rd_i,
   input  logic            iss_rd_we_i,
   input  logic            cmp_valid_i,
   output logic            cmp_ready_o,
   input  logic [4:0]      cmp_rd_i,
   input  logic [XLEN-1:0] cmp_data_i,
   output logic            wb_we_o,
   output logic [4:0]      wb_addr_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            fwd_rs1_o,
   output logic            fwd_rs2_o,
   output logic            err_o
);

   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [31:0]     busy_q;
   logic [31:0]     busy_d;
   logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
   // Extra MSB on each pointer separates full from empty.
   logic [PTR_W:0]  wr_ptr_q;
   logic [PTR_W:0]  rd_ptr_q;
   logic            err_q;

   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            iss_fire;
   logic            cmp_fire;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;
   logic            byp_rs1;
   logic            byp_rs2;
   logic            haz;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head_rd   = fifo_rd_q[rd_ptr_q[PTR_W-1:0]];
   assign head_data = fifo_data_q[rd_ptr_q[PTR_W-1:0]];

   // Drain whenever anything is queued; the register file always accepts.
   assign pop       = !empty;
   assign cmp_fire  = cmp_valid_i && !full;
   // Results for x0 are accepted but thrown away.
   assign push      = cmp_fire && (cmp_rd_i != 5'd0);

   // Write port: head of the FIFO, forced to zero when idle.
   always_comb begin
      wb_we_o   = !empty;
      wb_addr_o = 5'd0;
      wb_data_o = '0;
      if (!empty) begin
         wb_addr_o = head_rd;
         wb_data_o = head_data;
      end
   end

   // Bypass: the value a busy source is waiting for is on the write port now.
   always_comb begin
      byp_rs1 = 1'b0;
      byp_rs2 = 1'b0;
`ifdef WB_SCOREBOARD_BYPASS_EN
      byp_rs1 = wb_we_o && (wb_addr_o == iss_rs1_i) && (iss_rs1_i != 5'd0);
      byp_rs2 = wb_we_o && (wb_addr_o == iss_rs2_i) && (iss_rs2_i != 5'd0);
`endif
   end

   assign fwd_rs1_o   = byp_rs1;
   assign fwd_rs2_o   = byp_rs2;

   // The WAW term on rd is never bypassed: the old write must land first.
   assign haz         = (busy_q[iss_rs1_i] && !byp_rs1) ||
                        (busy_q[iss_rs2_i] && !byp_rs2) ||
                        (iss_rd_we_i && busy_q[iss_rd_i]);
   assign iss_ready_o = !haz;
   assign iss_fire    = iss_valid_i && iss_ready_o;
   assign cmp_ready_o = !full;
   assign err_o       = err_q;

   // Clear on pop, then set on issue; the two never target the same register
   // because issue stalls while rd is busy.
   // NOTE: combinational blocks use blocking '=' with a default assignment
   // first, so every path assigns every bit and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (iss_fire && iss_rd_we_i && (iss_rd_i != 5'd0)) begin
         busy_d[iss_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update
   // from the same pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         busy_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push && !busy_q[cmp_rd_i]) begin
            err_q <= 1'b1;
         end
      end
   end

   // NOTE: the FIFO storage has no reset; the pointers alone define which
   // entries are valid, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q[PTR_W-1:0]]   <= cmp_rd_i;
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= cmp_data_i;
      end
   end

endmodule

// File: tb/tb_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_wb_scoreboard
//
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a reference model made of a busy-bit array, a queue of pending
// results and a sticky error flag, updated once per clock edge.
// ---------------------------------------------------------------------------
module tb_wb_scoreboard;

   localparam int FIFO_DEPTH = 4;
   localparam int XLEN       = 32;
`ifdef WB_SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            iss_valid_i;
   logic            iss_ready_o;
   logic [4:0]      iss_rs1_i;
   logic [4:0]      iss_rs2_i;
   logic [4:0]      iss_rd_i;
   logic            iss_rd_we_i;
   logic            cmp_valid_i;
   logic            cmp_ready_o;
   logic [4:0]      cmp_rd_i;
   logic [XLEN-1:0] cmp_data_i;
   logic            wb_we_o;
   logic [4:0]      wb_addr_o;
   logic [XLEN-1:0] wb_data_o;
   logic            fwd_rs1_o;
   logic            fwd_rs2_o;
   logic            err_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   bit   m_busy [32];
   ent_t m_q [$];
   bit   m_err;

   always #5 clk_i = ~clk_i;

   wb_scoreboard #(.FIFO_DEPTH(FIFO_DEPTH), .XLEN(XLEN)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .iss_valid_i (iss_valid_i),
      .iss_ready_o (iss_ready_o),
      .iss_rs1_i   (iss_rs1_i),
      .iss_rs2_i   (iss_rs2_i),
      .iss_rd_i    (iss_rd_i),
      .iss_rd_we_i (iss_rd_we_i),
      .cmp_valid_i (cmp_valid_i),
      .cmp_ready_o (cmp_ready_o),
      .cmp_rd_i    (cmp_rd_i),
      .cmp_data_i  (cmp_data_i),
      .wb_we_o     (wb_we_o),
      .wb_addr_o   (wb_addr_o),
      .wb_data_o   (wb_data_o),
      .fwd_rs1_o   (fwd_rs1_o),
      .fwd_rs2_o   (fwd_rs2_o),
      .err_o       (err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_byp(input logic [4:0] rs);
      return BYP && (m_q.size() != 0) && (m_q[0].rd == rs) && (rs != 5'd0);
   endfunction

   function automatic bit model_ready();
      bit haz;
      haz = (m_busy[iss_rs1_i] && !model_byp(iss_rs1_i)) ||
            (m_busy[iss_rs2_i] && !model_byp(iss_rs2_i)) ||
            (iss_rd_we_i && m_busy[iss_rd_i]);
      return !haz;
   endfunction

   task automatic model_clear();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_q.delete();
      m_err = 1'b0;
   endtask

   // Apply inputs shortly after a rising edge, then compare all outputs.
   task automatic drive(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit we, input bit cv,
                        input logic [4:0] crd, input logic [31:0] cd);
      bit          e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      iss_valid_i = iv;
      iss_rs1_i   = r1;
      iss_rs2_i   = r2;
      iss_rd_i    = rd;
      iss_rd_we_i = we;
      cmp_valid_i = cv;
      cmp_rd_i    = crd;
      cmp_data_i  = cd;
      #1;
      e_we   = (m_q.size() != 0);
      e_addr = e_we ? m_q[0].rd : 5'd0;
      e_data = e_we ? m_q[0].data : 32'd0;
      check("wb_we",     wb_we_o,     e_we);
      check("wb_addr",   wb_addr_o,   e_addr);
      check("wb_data",   wb_data_o,   e_data);
      check("iss_ready", iss_ready_o, model_ready());
      check("cmp_ready", cmp_ready_o, m_q.size() < FIFO_DEPTH);
      check("fwd_rs1",   fwd_rs1_o,   model_byp(iss_rs1_i));
      check("fwd_rs2",   fwd_rs2_o,   model_byp(iss_rs2_i));
      check("err",       err_o,       m_err);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   // Advance one clock edge and move the model forward with the same inputs.
   task automatic tick();
      bit fire_iss;
      bit fire_cmp;
      bit err_set;
      fire_iss = iss_valid_i && model_ready();
      fire_cmp = cmp_valid_i && (m_q.size() < FIFO_DEPTH);
      err_set  = fire_cmp && (cmp_rd_i != 5'd0) && !m_busy[cmp_rd_i];
      @(posedge clk_i);
      if (!rst_i) begin
         model_clear();
      end else begin
         if (m_q.size() != 0) begin
            m_busy[m_q[0].rd] = 1'b0;
            void'(m_q.pop_front());
         end
         if (fire_iss && iss_rd_we_i && (iss_rd_i != 5'd0)) m_busy[iss_rd_i] = 1'b1;
         if (fire_cmp && (cmp_rd_i != 5'd0)) m_q.push_back('{rd: cmp_rd_i, data: cmp_data_i});
         if (err_set) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      idle();
      tick();
      rst_i = 1'b1;
   endtask

   initial begin : stim
      logic [4:0]  seq_rd [5];
      int          out_q [$];
      logic [4:0]  r1, r2, rd, crd;
      bit          iv, we, cv;
      int          idx;

      seq_rd[0] = 5'd3; seq_rd[1] = 5'd4; seq_rd[2] = 5'd6;
      seq_rd[3] = 5'd7; seq_rd[4] = 5'd8;

      // Bring the DUT out of an unknown power-up state before checking.
      rst_i       = 1'b0;
      iss_valid_i = 1'b0; iss_rs1_i = '0; iss_rs2_i = '0; iss_rd_i = '0;
      iss_rd_we_i = 1'b0; cmp_valid_i = 1'b0; cmp_rd_i = '0; cmp_data_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      model_clear();
      rst_i = 1'b1;

      // Reset state.
      idle();
      check("rst_wb_we", wb_we_o, 1'b0);
      check("rst_cmp_ready", cmp_ready_o, 1'b1);
      check("rst_err", err_o, 1'b0);

      // Issue rd=5, then a RAW on rs1=5 stalls.
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0);
      check("issue_rd5_ready", iss_ready_o, 1'b1);
      tick();
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      check("raw_rs1_stall", iss_ready_o, 1'b0);
      tick();

      // Completion of rd=5 at edge t.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      // Cycle t+1: result on the write port; rs2=5 bypass depends on build.
      drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      check("lat_wb_we", wb_we_o, 1'b1);
      check("lat_wb_addr", wb_addr_o, 5'd5);
      check("lat_wb_data", wb_data_o, 32'hDEADBEEF);
      check("byp_iss_ready", iss_ready_o, BYP);
      check("byp_fwd_rs2", fwd_rs2_o, BYP);
      tick();
      // Cycle t+2: busy[5] cleared.
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      check("post_wb_ready", iss_ready_o, 1'b1);
      tick();

      // Five distinct destinations, then back-to-back completions.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'd0, 5'd0, seq_rd[i], 1'b1, 1'b0, 5'd0, 32'd0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, seq_rd[i], 32'h1000 + 32'(i));
         if (i > 0) begin
            check("stream_addr", wb_addr_o, seq_rd[i-1]);
            check("stream_data", wb_data_o, 32'h1000 + 32'(i - 1));
         end
         tick();
      end
      idle();
      check("stream_last_addr", wb_addr_o, seq_rd[4]);
      check("stream_last_data", wb_data_o, 32'h1004);
      tick();
      idle();
      check("stream_drained", wb_we_o, 1'b0);
      check("stream_no_err", err_o, 1'b0);
      tick();

      // Completion for a non-busy register raises the sticky error.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h99);
      tick();
      idle();
      check("err_set", err_o, 1'b1);
      check("err_entry_pushed", wb_addr_o, 5'd9);
      tick();
      // Completion to x0 is dropped.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h55);
      tick();
      idle();
      check("x0_no_wb", wb_we_o, 1'b0);
      check("err_sticky", err_o, 1'b1);
      tick();

      // Reset mid-operation with busy registers and a pending entry.
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 5'd1, 32'hA1);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 32'hA10);
      do_reset();
      drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 5'd0, 32'd0);
      check("mid_rst_wb_we", wb_we_o, 1'b0);
      check("mid_rst_ready", iss_ready_o, 1'b1);
      check("mid_rst_err", err_o, 1'b0);
      tick();
      do_reset();

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 600; cyc++) begin
         iv  = 1'($urandom_range(0, 1));
         r1  = 5'($urandom_range(0, 9));
         r2  = 5'($urandom_range(0, 9));
         rd  = 5'($urandom_range(0, 9));
         we  = 1'($urandom_range(0, 1));
         cv  = 1'b0;
         crd = 5'd0;
         if ((out_q.size() != 0) && ($urandom_range(0, 2) != 0)) begin
            idx = int'($urandom_range(0, out_q.size() - 1));
            cv  = 1'b1;
            crd = 5'(out_q[idx]);
            out_q.delete(idx);
         end else if ($urandom_range(0, 31) == 0) begin
            cv  = 1'b1;
            crd = 5'($urandom_range(0, 31));
         end
         rst_i = ($urandom_range(0, 99) != 0);
         drive(iv, r1, r2, rd, we, cv, crd, $urandom);
         if (!rst_i) begin
            out_q.delete();
         end else if (iv && model_ready() && we && (rd != 5'd0)) begin
            out_q.push_back(int'(rd));
         end
         tick();
      end
      rst_i = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
